// File: rtl/image_stream_source_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : image_stream_source_if
// Description : Memory-read and pixel-stream bus of the image stream source.
//               master = the source, slave = memory + image pipeline.
// Revision    : 1.0  initial release
// ============================================================================
interface image_stream_source_if #(
  parameter int AW = 18
);
  logic          o_mem_en;
  logic [AW-1:0] o_mem_addr;
  logic [7:0]    i_mem_data;
  logic          o_data_valid;
  logic [7:0]    o_data;
  logic          o_data_last;
  logic          i_data_ready;

  modport master (
    output o_mem_en, o_mem_addr, o_data_valid, o_data, o_data_last,
    input  i_mem_data, i_data_ready
  );

  modport slave (
    input  o_mem_en, o_mem_addr, o_data_valid, o_data, o_data_last,
    output i_mem_data, i_data_ready
  );
endinterface
`default_nettype wire

// File: rtl/image_stream_source.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : image_stream_source
// Description : Reads an image from memory in raster order and streams it as
//               AXI-stream pixels, line by line, gated by line credits that
//               the downstream pipeline returns through i_intr.
// Revision    : 1.0  initial release
// ============================================================================
module image_stream_source #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int INIT_LINES = 4,
  parameter int AW         = 18
) (
  input  wire logic               i_clk,
  input  wire logic               i_rst,
  input  wire logic               i_start,
  output logic                    o_busy,
  output logic                    o_done,
  input  wire logic               i_intr,
  image_stream_source_if.master   m_bus
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int LW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] c_COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [LW-1:0] c_LINE_LAST = LW'(IMG_HEIGHT - 1);
  localparam logic [3:0]    c_INIT_CRED = 4'(INIT_LINES);
  localparam logic [3:0]    c_CRED_MAX  = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_WAIT  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_col;
  logic [LW-1:0] r_line;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_credits;
  logic          r_busy;
  logic          r_done;

  // read in flight: data appears on i_mem_data in the cycle r_rd_pend is high
  logic          r_rd_pend;
  logic          r_rd_last;

  // two-entry output FIFO: head drives the stream, skid catches one extra
  logic          r_head_vld;
  logic [7:0]    r_head_data;
  logic          r_head_last;
  logic          r_skid_vld;
  logic [7:0]    r_skid_data;
  logic          r_skid_last;

  logic          w_pop;
  logic [1:0]    w_occ;
  logic          w_room;
  logic          w_line_start;
  logic          w_issue;
  logic          w_col_end;
  logic          w_cred_inc;
  logic          w_cred_dec;
  logic [3:0]    w_cred_next;
  logic          w_empty;

  assign w_pop        = r_head_vld & m_bus.i_data_ready;
  assign w_occ        = {1'b0, r_head_vld} + {1'b0, r_skid_vld} + {1'b0, r_rd_pend};
  // occupancy is counted after this cycle's pop so a steady 1 pixel/cycle fits
  assign w_room       = (w_occ - {1'b0, w_pop}) < 2'd2;
  assign w_line_start = (r_col == '0);
  assign w_issue      = (r_state == S_SEND) && w_room &&
                        (!w_line_start || (r_credits != 4'd0));
  assign w_col_end    = w_issue && (r_col == c_COL_LAST);
  assign w_cred_inc   = i_intr && (r_state != S_IDLE);
  assign w_cred_dec   = w_issue && w_line_start;
  assign w_empty      = !r_head_vld && !r_skid_vld && !r_rd_pend;

  // credit update: saturating increment, simultaneous inc/dec cancel
  always_comb begin
    w_cred_next = r_credits;
    case ({w_cred_inc, w_cred_dec})
      2'b10:   if (r_credits != c_CRED_MAX) w_cred_next = r_credits + 4'd1;
      2'b01:   w_cred_next = r_credits - 4'd1;
      default: w_cred_next = r_credits;
    endcase
  end

  // frame control FSM: line/column/address counters, credits, busy/done
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_col     <= '0;
      r_line    <= '0;
      r_addr    <= '0;
      r_credits <= 4'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_credits <= w_cred_next;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_SEND;
            r_credits <= c_INIT_CRED;
            r_col     <= '0;
            r_line    <= '0;
            r_addr    <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_SEND: begin
          if (w_issue) begin
            r_addr <= r_addr + AW'(1);
            if (w_col_end) begin
              r_col <= '0;
              if (r_line == c_LINE_LAST) begin
                r_state <= S_FLUSH;
              end else begin
                r_line  <= r_line + LW'(1);
                r_state <= (w_cred_next != 4'd0) ? S_SEND : S_WAIT;
              end
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        S_WAIT: begin
          if (r_credits != 4'd0) r_state <= S_SEND;
        end
        S_FLUSH: begin
          if (w_empty) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // read return capture and two-entry output FIFO
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_pend   <= 1'b0;
      r_rd_last   <= 1'b0;
      r_head_vld  <= 1'b0;
      r_head_data <= 8'd0;
      r_head_last <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_skid_data <= 8'd0;
      r_skid_last <= 1'b0;
    end else begin
      r_rd_pend <= w_issue;
      r_rd_last <= w_col_end;
      if (!r_head_vld || w_pop) begin
        if (r_skid_vld) begin
          r_head_vld  <= 1'b1;
          r_head_data <= r_skid_data;
          r_head_last <= r_skid_last;
          r_skid_vld  <= r_rd_pend;
          r_skid_data <= m_bus.i_mem_data;
          r_skid_last <= r_rd_last;
        end else begin
          r_head_vld <= r_rd_pend;
          if (r_rd_pend) begin
            r_head_data <= m_bus.i_mem_data;
            r_head_last <= r_rd_last;
          end
        end
      end else if (r_rd_pend) begin
        r_skid_vld  <= 1'b1;
        r_skid_data <= m_bus.i_mem_data;
        r_skid_last <= r_rd_last;
      end
    end
  end

  assign m_bus.o_mem_en     = w_issue;
  assign m_bus.o_mem_addr   = r_addr;
  assign m_bus.o_data_valid = r_head_vld;
  assign m_bus.o_data       = r_head_data;
  assign m_bus.o_data_last  = r_head_last;
  assign o_busy             = r_busy;
  assign o_done             = r_done;

endmodule
`default_nettype wire

// File: tb/tb_image_stream_source.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_image_stream_source
// Description : Scoreboard bench for image_stream_source, 8x6 image,
//               memory model returns mem[a] = a.
// Revision    : 1.0  initial release
// ============================================================================
module tb_image_stream_source;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int INIT = 4;
  localparam int AW   = 8;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic intr;
  logic busy;
  logic done;

  image_stream_source_if #(.AW(AW)) bus ();

  image_stream_source #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .INIT_LINES(INIT),
    .AW        (AW)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_start(start),
    .o_busy (busy),
    .o_done (done),
    .i_intr (intr),
    .m_bus  (bus)
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    beats = 0;
  int    dones = 0;
  int    reads = 0;
  int    beat_at [0:1023];
  logic  prev_stall = 1'b0;
  logic [8:0] prev_beat = 9'd0;
  logic  rand_rdy = 1'b0;
  logic [15:0] pat = 16'b0110_1001_1100_0101;
  int    pidx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // memory model: one-cycle read latency
  always @(posedge clk) begin
    if (bus.o_mem_en) bus.i_mem_data <= bus.o_mem_addr[7:0];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: pops the scoreboard on each handshake, checks stall stability
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall <= 1'b0;
    end else begin
      if (bus.o_mem_en) reads <= reads + 1;
      if (done) begin
        dones <= dones + 1;
        check("busy_low_with_done", 32'(busy), 32'd0);
      end
      if (prev_stall) begin
        check("valid_held", 32'(bus.o_data_valid), 32'd1);
        check("beat_held", 32'({bus.o_data_last, bus.o_data}), 32'(prev_beat));
      end
      if (bus.o_data_valid && bus.i_data_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got data %0d, no beat expected", bus.o_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", 32'(bus.o_data), 32'(e.data));
          check("beat_last", 32'(bus.o_data_last), 32'(e.last));
        end
        beat_at[beats] <= cyc;
        beats <= beats + 1;
      end
      prev_stall <= bus.o_data_valid && !bus.i_data_ready;
      prev_beat  <= {bus.o_data_last, bus.o_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      bus.i_data_ready = pat[pidx];
      pidx = (pidx + 1) % 16;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; intr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push_frame(input int n);
    for (int a = 0; a < n; a++) begin
      beat_t b;
      b.last = ((a % W) == (W - 1));
      b.data = 8'(a);
      exp_q.push_back(b);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_intr();
    intr = 1'b1; tick(); intr = 1'b0;
  endtask

  task automatic drain(input int target, input int budget);
    int k;
    k = 0;
    while (beats < target && k < budget) begin
      tick();
      k++;
    end
    total++;
    if (beats < target) begin
      bad++;
      $display("FAIL drain_timeout: got %0d beats, want %0d", beats, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, bd, r0, lat, k;
    rst = 1'b1; start = 1'b0; intr = 1'b0;
    bus.i_data_ready = 1'b1;

    // reset values
    tick(); tick();
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_mem_en", 32'(bus.o_mem_en), 32'd0);
    check("rst_mem_addr", 32'(bus.o_mem_addr), 32'd0);
    check("rst_valid", 32'(bus.o_data_valid), 32'd0);
    check("rst_data",  32'(bus.o_data), 32'd0);
    check("rst_last",  32'(bus.o_data_last), 32'd0);
    rst = 1'b0;
    tick();

    // initial credits only: 32 pixels then stall in WAIT
    base = beats; bd = dones;
    push_frame(32);
    pulse_start();
    lat = 0;
    while (!bus.o_data_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat > 4) begin
      bad++;
      $display("FAIL start_latency: got %0d cycles, want <= 4", lat);
    end
    drain(base + 32, 200);
    r0 = reads;
    repeat (20) tick();
    check("no_reads_in_wait", 32'(reads - r0), 32'd0);
    check("no_valid_in_wait", 32'(bus.o_data_valid), 32'd0);
    check("busy_in_wait", 32'(busy), 32'd1);
    check("no_done_4_lines", 32'(dones - bd), 32'd0);
    check("gap_4_lines", 32'(beat_at[base + 31] - beat_at[base]), 32'd31);
    do_reset();

    // full frame with two returned credits
    base = beats; bd = dones;
    push_frame(48);
    pulse_start();
    repeat (3) tick();
    pulse_intr();
    tick();
    pulse_intr();
    drain(base + 48, 300);
    repeat (5) tick();
    check("done_count_full", 32'(dones - bd), 32'd1);
    check("busy_after_full", 32'(busy), 32'd0);
    check("gap_full", 32'(beat_at[base + 47] - beat_at[base]), 32'd47);

    // throttled ready
    base = beats; bd = dones;
    pidx = 0; rand_rdy = 1'b1;
    push_frame(48);
    pulse_start();
    repeat (3) tick();
    pulse_intr();
    tick();
    pulse_intr();
    drain(base + 48, 600);
    rand_rdy = 1'b0;
    bus.i_data_ready = 1'b1;
    repeat (6) tick();
    check("done_count_rand", 32'(dones - bd), 32'd1);
    check("busy_after_rand", 32'(busy), 32'd0);

    // credit arrives with last read of line 3 and with first read of line 4
    base = beats; bd = dones;
    push_frame(48);
    pulse_start();
    k = 0;
    while (!(bus.o_mem_en && bus.o_mem_addr == AW'(31)) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("found_read_31", 32'(bus.o_mem_en && bus.o_mem_addr == AW'(31)), 32'd1);
    intr = 1'b1;
    @(posedge clk);
    #1;
    intr = 1'b0;
    check("line4_read_no_stall", 32'(bus.o_mem_en), 32'd1);
    check("line4_first_addr", 32'(bus.o_mem_addr), 32'd32);
    pulse_intr();
    drain(base + 48, 300);
    repeat (5) tick();
    check("done_count_coinc", 32'(dones - bd), 32'd1);
    check("gap_coinc", 32'(beat_at[base + 47] - beat_at[base]), 32'd47);

    // reset mid-frame, then restart from address 0
    base = beats; bd = dones;
    push_frame(48);
    pulse_start();
    pulse_intr();
    k = 0;
    while (beats < base + 20 && k < 100) begin
      tick();
      k++;
    end
    check("reached_beat_20", 32'(beats >= base + 20), 32'd1);
    rst = 1'b1;
    tick(); tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(bus.o_data_valid), 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    check("midrst_no_done", 32'(dones - bd), 32'd0);
    base = beats;
    push_frame(48);
    pulse_start();
    pulse_intr();
    pulse_intr();
    drain(base + 48, 300);
    repeat (5) tick();
    check("restart_done", 32'(dones - bd), 32'd1);

    // second start mid-frame is ignored
    base = beats; bd = dones;
    push_frame(48);
    pulse_start();
    repeat (10) tick();
    pulse_start();
    pulse_intr();
    pulse_intr();
    drain(base + 48, 300);
    repeat (5) tick();
    check("restart_ignored_done", 32'(dones - bd), 32'd1);
    check("restart_ignored_gap", 32'(beat_at[base + 47] - beat_at[base]), 32'd47);
    check("restart_ignored_busy", 32'(busy), 32'd0);
    check("queue_empty_end", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
